// File: rtl/mouse_pkg.sv
// Shared state encoding and PS/2 command/response bytes for the mouse command scheduler.
package mouse_pkg;

  typedef enum logic [3:0] {
    ST_INIT_LOAD = 4'd0,
    ST_SEND      = 4'd1,
    ST_WAIT_SENT = 4'd2,
    ST_WAIT_ACK  = 4'd3,
    ST_WAIT_BAT  = 4'd4,
    ST_WAIT_ID   = 4'd5,
    ST_RETRY     = 4'd6,
    ST_NEXT      = 4'd7,
    ST_FAIL      = 4'd8,
    ST_FAULT     = 4'd9,
    ST_STREAM    = 4'd10
  } state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mouse_timeout_ctr.sv
// Saturating cycle counter: counts while enabled, flags expiry at limit-1, holds there until cleared.
module mouse_timeout_ctr #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  always_comb begin
    expired = (count >= (limit - ONE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/mouse_cmd_scheduler.sv
// Sequences the PS/2 mouse init handshake and single-byte CPU commands over a shared TX/RX pair,
// with per-command retries, timeouts and a timed fault-hold before re-initialising.
module mouse_cmd_scheduler
  import mouse_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT_CYC = 2_500_000,
  parameter int unsigned BAT_TIMEOUT_CYC = 50_000_000,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned FAULT_HOLD_CYC  = 5_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic       BYTE_READY,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       CPU_CMD_REQ,
  input  logic [7:0] CPU_CMD_BYTE,
  output logic       CPU_CMD_DONE,
  output logic       CPU_CMD_ERR,
  output logic       STREAM_EN,
  output logic       MOUSE_FAULT,
  output logic [3:0] current_state
);

  localparam int unsigned TW = $clog2(max_u(BAT_TIMEOUT_CYC, FAULT_HOLD_CYC) + 1);
  localparam int unsigned RW = max_u(2, $clog2(MAX_RETRIES + 1));
  localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TIMEOUT_CYC);
  localparam logic [TW-1:0] BAT_LIM   = TW'(BAT_TIMEOUT_CYC);
  localparam logic [TW-1:0] HOLD_LIM  = TW'(FAULT_HOLD_CYC);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_ONE = RW'(1);

  state_t          state, state_d;
  logic [7:0]      cmd, cmd_d;
  logic [RW-1:0]   retry, retry_d;
  logic            init_step, init_step_d;
  logic            is_cpu, is_cpu_d;
  logic            need_drop, need_drop_d;
  logic            cpu_pending;
  logic            byte_ok;
  logic            timer_en, timer_clr, expired;
  logic [TW-1:0]   limit;

  // A request stays blocked after DONE until the CPU drops it, so a held level cannot re-trigger.
  always_comb begin
    cpu_pending = CPU_CMD_REQ && !need_drop;
    byte_ok     = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  end

  always_comb begin
    state_d     = state;
    cmd_d       = cmd;
    retry_d     = retry;
    init_step_d = init_step;
    is_cpu_d    = is_cpu;
    case (state)
      ST_INIT_LOAD: begin
        cmd_d       = CMD_RESET;
        retry_d     = '0;
        init_step_d = 1'b0;
        is_cpu_d    = 1'b0;
        state_d     = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT_SENT;
      ST_WAIT_SENT: begin
        if (BYTE_SENT)    state_d = ST_WAIT_ACK;
        else if (expired) state_d = ST_RETRY;
      end
      ST_WAIT_ACK: begin
        if (BYTE_READY) begin
          if (byte_ok && BYTE_READ == RSP_ACK)
            state_d = (cmd == CMD_RESET) ? ST_WAIT_BAT : ST_NEXT;
          else
            state_d = ST_RETRY;
        end else if (expired) begin
          state_d = ST_RETRY;
        end
      end
      ST_WAIT_BAT: begin
        if (BYTE_READY)   state_d = (byte_ok && BYTE_READ == RSP_BAT_OK) ? ST_WAIT_ID : ST_RETRY;
        else if (expired) state_d = ST_RETRY;
      end
      ST_WAIT_ID: begin
        if (BYTE_READY)   state_d = (byte_ok && BYTE_READ == RSP_ID) ? ST_NEXT : ST_RETRY;
        else if (expired) state_d = ST_RETRY;
      end
      ST_RETRY: begin
        if (retry < RETRY_LIM) begin
          retry_d = retry + RETRY_ONE;
          state_d = ST_SEND;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_NEXT: begin
        if (is_cpu) begin
          is_cpu_d = 1'b0;
          state_d  = ST_STREAM;
        end else if (!init_step) begin
          cmd_d       = CMD_ENABLE;
          retry_d     = '0;
          init_step_d = 1'b1;
          state_d     = ST_SEND;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_FAIL: begin
        if (is_cpu) begin
          is_cpu_d = 1'b0;
          state_d  = ST_STREAM;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (expired) state_d = ST_INIT_LOAD;
      end
      ST_STREAM: begin
        if (cpu_pending) begin
          cmd_d    = CPU_CMD_BYTE;
          retry_d  = '0;
          is_cpu_d = 1'b1;
          state_d  = ST_SEND;
        end
      end
      default: state_d = ST_INIT_LOAD;
    endcase
  end

  always_comb begin
    SEND_BYTE     = (state == ST_SEND);
    BYTE_TO_SEND  = cmd;
    READ_ENABLE   = state inside {ST_WAIT_ACK, ST_WAIT_BAT, ST_WAIT_ID, ST_STREAM};
    STREAM_EN     = (state == ST_STREAM);
    MOUSE_FAULT   = (state == ST_FAULT);
    CPU_CMD_DONE  = is_cpu && (state == ST_NEXT || state == ST_FAIL);
    CPU_CMD_ERR   = is_cpu && (state == ST_FAIL);
    current_state = state;
    need_drop_d   = need_drop;
    if (CPU_CMD_DONE)      need_drop_d = 1'b1;
    else if (!CPU_CMD_REQ) need_drop_d = 1'b0;
  end

  // Timer restarts on every state change, so each timed state sees a fresh count.
  always_comb begin
    timer_en  = state inside {ST_WAIT_SENT, ST_WAIT_ACK, ST_WAIT_BAT, ST_WAIT_ID, ST_FAULT};
    timer_clr = !timer_en || (state_d != state);
    limit     = ACK_LIM;
    if (state inside {ST_WAIT_BAT, ST_WAIT_ID}) limit = BAT_LIM;
    else if (state == ST_FAULT)                 limit = HOLD_LIM;
  end

  mouse_timeout_ctr #(.WIDTH(TW)) u_timer (
    .clk     (CLK),
    .rst_n   (RESET),
    .clear   (timer_clr),
    .enable  (timer_en),
    .limit   (limit),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_INIT_LOAD;
      cmd       <= '0;
      retry     <= '0;
      init_step <= 1'b0;
      is_cpu    <= 1'b0;
      need_drop <= 1'b0;
    end else begin
      state     <= state_d;
      cmd       <= cmd_d;
      retry     <= retry_d;
      init_step <= init_step_d;
      is_cpu    <= is_cpu_d;
      need_drop <= need_drop_d;
    end
  end

endmodule

// File: tb/tb_mouse_cmd_scheduler.sv
// Directed + randomized bench: a mouse BFM answers each command attempt, an attempt-count model
// predicts sends, completion status, stream gating and fault-hold duration.
module tb_mouse_cmd_scheduler;

  localparam int unsigned ACK_T  = 100;
  localparam int unsigned BAT_T  = 300;
  localparam int unsigned MAXR   = 3;
  localparam int unsigned HOLD_T = 200;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic       BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       CPU_CMD_REQ;
  logic [7:0] CPU_CMD_BYTE;
  logic       CPU_CMD_DONE;
  logic       CPU_CMD_ERR;
  logic       STREAM_EN;
  logic       MOUSE_FAULT;
  logic [3:0] current_state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 CLK = ~CLK;

  mouse_cmd_scheduler #(
    .ACK_TIMEOUT_CYC (ACK_T),
    .BAT_TIMEOUT_CYC (BAT_T),
    .MAX_RETRIES     (MAXR),
    .FAULT_HOLD_CYC  (HOLD_T)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .SEND_BYTE       (SEND_BYTE),
    .BYTE_TO_SEND    (BYTE_TO_SEND),
    .BYTE_SENT       (BYTE_SENT),
    .READ_ENABLE     (READ_ENABLE),
    .BYTE_READY      (BYTE_READY),
    .BYTE_READ       (BYTE_READ),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .CPU_CMD_REQ     (CPU_CMD_REQ),
    .CPU_CMD_BYTE    (CPU_CMD_BYTE),
    .CPU_CMD_DONE    (CPU_CMD_DONE),
    .CPU_CMD_ERR     (CPU_CMD_ERR),
    .STREAM_EN       (STREAM_EN),
    .MOUSE_FAULT     (MOUSE_FAULT),
    .current_state   (current_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0; BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_ERROR_CODE = '0; CPU_CMD_REQ = 1'b0;
    tick();
    chk("rst_send_byte", 32'(SEND_BYTE), 0);
    chk("rst_read_en", 32'(READ_ENABLE), 0);
    chk("rst_stream_en", 32'(STREAM_EN), 0);
    chk("rst_fault", 32'(MOUSE_FAULT), 0);
    chk("rst_done", 32'(CPU_CMD_DONE), 0);
    chk("rst_err", 32'(CPU_CMD_ERR), 0);
    chk("rst_byte", 32'(BYTE_TO_SEND), 0);
    chk("rst_state", 32'(current_state), 0);
    tick();
    RESET = 1'b1;
  endtask

  task automatic wait_send(output logic [7:0] b, output logic found);
    found = 1'b0;
    b = '0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (SEND_BYTE) begin
        found = 1'b1;
        b = BYTE_TO_SEND;
      end else begin
        tick();
      end
    end
  endtask

  // Transmitter completion; optional stray receiver bytes during SEND/WAIT_SENT must be ignored.
  task automatic pulse_sent();
    int unsigned stray;
    stray = $urandom_range(0, 1);
    if (stray != 0) begin
      BYTE_READY = 1'b1; BYTE_READ = 8'hFE; BYTE_ERROR_CODE = '0;
    end
    tick();
    repeat ($urandom_range(0, 3)) tick();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0; BYTE_READY = 1'b0;
  endtask

  task automatic rx(input logic [7:0] d, input logic [1:0] e);
    repeat ($urandom_range(0, 3)) tick();
    BYTE_READY = 1'b1; BYTE_READ = d; BYTE_ERROR_CODE = e;
    tick();
    BYTE_READY = 1'b0; BYTE_READ = 8'($urandom); BYTE_ERROR_CODE = '0;
  endtask

  // One command: the first n_bad attempts are answered badly; at most MAXR+1 attempts are made.
  task automatic run_cmd(input logic [7:0] cmd, input int unsigned n_bad, input int kind_sel,
                         input logic cpu, input logic req_at_bat);
    int unsigned attempts, kind, extra, cnt;
    logic [7:0] b, d;
    logic found;
    attempts = (n_bad > MAXR) ? MAXR + 1 : n_bad + 1;
    for (int unsigned a = 0; a < attempts; a++) begin
      wait_send(b, found);
      chk("send_seen", 32'(found), 1);
      chk("send_byte", 32'(b), 32'(cmd));
      if (cpu) begin
        chk("stream_en_busy", 32'(STREAM_EN), 0);
        CPU_CMD_BYTE = ~cmd;
      end
      pulse_sent();
      chk("byte_hold", 32'(BYTE_TO_SEND), 32'(cmd));
      chk("read_en_ack", 32'(READ_ENABLE), 1);
      if (a < n_bad) begin
        kind = (kind_sel >= 0) ? kind_sel : $urandom_range(0, (cmd == 8'hFF) ? 4 : 3);
        case (kind)
          0: rx(8'hFE, 2'b00);
          1: begin
            d = 8'($urandom_range(0, 255));
            if (d == 8'hFA) d = 8'h5A;
            rx(d, 2'b00);
          end
          2: rx(8'hFA, 2'($urandom_range(1, 3)));
          3: ;
          default: begin
            rx(8'hFA, 2'b00);
            rx(8'hFC, 2'b00);
          end
        endcase
      end else begin
        rx(8'hFA, 2'b00);
        if (cmd == 8'hFF) begin
          if (req_at_bat) begin
            CPU_CMD_REQ = 1'b1; CPU_CMD_BYTE = 8'hF5;
          end
          rx(8'hAA, 2'b00);
          rx(8'h00, 2'b00);
        end
        if (cpu) begin
          chk("done_ok", 32'(CPU_CMD_DONE), 1);
          chk("err_ok", 32'(CPU_CMD_ERR), 0);
          chk("stream_en_at_done", 32'(STREAM_EN), 0);
          tick();
          chk("stream_en_after", 32'(STREAM_EN), 1);
          chk("done_pulse", 32'(CPU_CMD_DONE), 0);
        end else if (cmd == 8'hF4) begin
          chk("stream_en_1cyc", 32'(STREAM_EN), 0);
          tick();
          chk("stream_en_2cyc", 32'(STREAM_EN), 1);
          chk("no_fault", 32'(MOUSE_FAULT), 0);
        end
      end
    end
    if (n_bad > MAXR) begin
      found = 1'b0;
      extra = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
        if (cpu ? CPU_CMD_DONE : MOUSE_FAULT) found = 1'b1;
        else begin
          if (SEND_BYTE) extra++;
          tick();
        end
      end
      chk(cpu ? "fail_done_seen" : "fault_seen", 32'(found), 1);
      chk("no_extra_send", extra, 0);
      if (cpu) begin
        chk("fail_err", 32'(CPU_CMD_ERR), 1);
        tick();
        chk("stream_after_fail", 32'(STREAM_EN), 1);
      end else begin
        cnt = 0;
        while (MOUSE_FAULT && cnt < HOLD_T + 10) begin
          cnt++;
          tick();
        end
        chk("fault_hold_len", cnt, HOLD_T);
      end
    end
  endtask

  task automatic cpu_cmd(input logic [7:0] c, input int unsigned n_bad);
    CPU_CMD_REQ = 1'b1; CPU_CMD_BYTE = c;
    run_cmd(c, n_bad, -1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_retrigger", 32'(SEND_BYTE), 0);
      chk("stream_hold", 32'(STREAM_EN), 1);
    end
    CPU_CMD_REQ = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] b;
    logic found;
    RESET = 1'b0; BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_READ = '0;
    BYTE_ERROR_CODE = '0; CPU_CMD_REQ = 1'b0; CPU_CMD_BYTE = '0;

    // Clean init, stream idle with receiver traffic, then CPU commands.
    do_reset();
    run_cmd(8'hFF, 0, -1, 1'b0, 1'b0);
    run_cmd(8'hF4, 0, -1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      BYTE_READY = 1'b1; BYTE_READ = 8'($urandom); BYTE_ERROR_CODE = 2'($urandom);
      tick();
      chk("stream_ignore_send", 32'(SEND_BYTE), 0);
      chk("stream_ignore_en", 32'(STREAM_EN), 1);
    end
    BYTE_READY = 1'b0;
    cpu_cmd(8'hF5, 0);
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b = 8'hFF;
      cpu_cmd(b, $urandom_range(0, 4));
    end

    // FE answered to the first F4.
    do_reset();
    run_cmd(8'hFF, 0, -1, 1'b0, 1'b0);
    run_cmd(8'hF4, 1, 0, 1'b0, 1'b0);

    // FA with a receive error is not an ack.
    do_reset();
    run_cmd(8'hFF, 1, 2, 1'b0, 1'b0);
    run_cmd(8'hF4, 0, -1, 1'b0, 1'b0);

    // Silent mouse: four FF attempts, fault hold, then init restarts.
    do_reset();
    run_cmd(8'hFF, 4, 3, 1'b0, 1'b0);
    run_cmd(8'hFF, 0, -1, 1'b0, 1'b0);
    run_cmd(8'hF4, 0, -1, 1'b0, 1'b0);

    // Reset while awaiting the F4 ack; CPU request raised during BAT wait is deferred.
    do_reset();
    run_cmd(8'hFF, 0, -1, 1'b0, 1'b0);
    wait_send(b, found);
    chk("f4_seen", 32'(found), 1);
    chk("f4_byte", 32'(b), 32'hF4);
    pulse_sent();
    chk("in_wait_ack", 32'(READ_ENABLE), 1);
    do_reset();
    run_cmd(8'hFF, 0, -1, 1'b0, 1'b1);
    run_cmd(8'hF4, 0, -1, 1'b0, 1'b0);
    cpu_cmd(8'hF5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
